alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared ArithmeticLogicUnit. It accepts operation requests (operands, FunSel, WF) from two requesters over valid/ready and grants the ALU round-robin. It drives the ALU for a fixed two-cycle issue/capture sequence so the registered flags settle, then returns result and flags to the winner as a one-cycle response pulse. It sits between the control unit (port 0), the address-generation path (port 1) and the single ALU instance.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that sequences the shared ALU through a fixed
// issue/capture cycle pair and returns the result to the winning requester as a one-cycle pulse.
module alu_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNSEL_WIDTH = 5
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Req0Valid,
    output logic                    Req0Ready,
    input  logic [DATA_WIDTH-1:0]   Req0A,
    input  logic [DATA_WIDTH-1:0]   Req0B,
    input  logic [FUNSEL_WIDTH-1:0] Req0FunSel,
    input  logic                    Req0WF,
    input  logic                    Req1Valid,
    output logic                    Req1Ready,
    input  logic [DATA_WIDTH-1:0]   Req1A,
    input  logic [DATA_WIDTH-1:0]   Req1B,
    input  logic [FUNSEL_WIDTH-1:0] Req1FunSel,
    input  logic                    Req1WF,
    output logic                    Rsp0Valid,
    output logic                    Rsp1Valid,
    output logic [DATA_WIDTH-1:0]   RspData,
    output logic [3:0]              RspFlags,
    output logic [DATA_WIDTH:0]     AluA,
    output logic [DATA_WIDTH:0]     AluB,
    output logic [FUNSEL_WIDTH-1:0] AluFunSel,
    output logic                    AluWF,
    input  logic [DATA_WIDTH:0]     AluOut,
    input  logic [3:0]              AluFlags
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESPOND
    } state_t;

    state_t state;
    state_t next_state;

    logic                    last_grant;
    logic                    owner;
    logic                    grant0;
    logic                    grant1;
    logic [DATA_WIDTH-1:0]   alu_a;
    logic [DATA_WIDTH-1:0]   alu_b;
    logic [FUNSEL_WIDTH-1:0] alu_funsel;
    logic                    alu_wf;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [3:0]              rsp_flags;
    logic                    rsp0_valid;
    logic                    rsp1_valid;
    logic                    unused_alu_msb;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        grant0    = Req0Valid & (~Req1Valid | last_grant);
        grant1    = Req1Valid & (~Req0Valid | ~last_grant);
        Req0Ready = (state == IDLE) & ~Reset & grant0;
        Req1Ready = (state == IDLE) & ~Reset & grant1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (Req0Ready | Req1Ready) next_state = ISSUE;
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The ALU drive registers double as the operand latches for the whole operation.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_funsel <= '0;
            alu_wf     <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Req0Ready) begin
                        alu_a      <= Req0A;
                        alu_b      <= Req0B;
                        alu_funsel <= Req0FunSel;
                        alu_wf     <= Req0WF;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                    end else if (Req1Ready) begin
                        alu_a      <= Req1A;
                        alu_b      <= Req1B;
                        alu_funsel <= Req1FunSel;
                        alu_wf     <= Req1WF;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                ISSUE: begin
                    alu_wf <= 1'b0;
                end
                CAPTURE: begin
                    // Flags written at the end of ISSUE are stable here.
                    rsp_data   <= AluOut[DATA_WIDTH-1:0];
                    rsp_flags  <= AluFlags;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    alu_funsel <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign unused_alu_msb = AluOut[DATA_WIDTH];

    assign AluA      = {1'b0, alu_a};
    assign AluB      = {1'b0, alu_b};
    assign AluFunSel = alu_funsel;
    assign AluWF     = alu_wf;
    assign RspData   = rsp_data;
    assign RspFlags  = rsp_flags;
    assign Rsp0Valid = rsp0_valid;
    assign Rsp1Valid = rsp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a stub ALU with a registered flag bank, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_alu_arbiter;

    localparam logic [4:0] ADD = 5'b10100;
    localparam logic [4:0] SUB = 5'b10101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_funsel, req1_funsel;
    logic        req0_wf, req1_wf;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic [32:0] alu_a, alu_b;
    logic [4:0]  alu_funsel;
    logic        alu_wf;
    logic [32:0] alu_out;
    logic [3:0]  alu_flags = 4'b0000;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_WIDTH(32), .FUNSEL_WIDTH(5)) dut (
        .Clock(clk), .Reset(rst),
        .Req0Valid(req0_valid), .Req0Ready(req0_ready), .Req0A(req0_a), .Req0B(req0_b),
        .Req0FunSel(req0_funsel), .Req0WF(req0_wf),
        .Req1Valid(req1_valid), .Req1Ready(req1_ready), .Req1A(req1_a), .Req1B(req1_b),
        .Req1FunSel(req1_funsel), .Req1WF(req1_wf),
        .Rsp0Valid(rsp0_valid), .Rsp1Valid(rsp1_valid), .RspData(rsp_data), .RspFlags(rsp_flags),
        .AluA(alu_a), .AluB(alu_b), .AluFunSel(alu_funsel), .AluWF(alu_wf),
        .AluOut(alu_out), .AluFlags(alu_flags)
    );

    // Stub ALU: {carry, result}; flags {O,N,C,Z}, C is carry for add and borrow for sub
    function automatic logic [32:0] aluCalc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] fs);
        if (fs == ADD) return {1'b0, a} + {1'b0, b};
        if (fs == SUB) return {1'b0, a} - {1'b0, b};
        return {1'b0, a ^ b};
    endfunction

    function automatic logic [3:0] aluFlags(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] fs);
        logic [32:0] r;
        logic        o;
        r = aluCalc(a, b, fs);
        o = 1'b0;
        if (fs == ADD) o = (a[31] == b[31]) && (r[31] != a[31]);
        if (fs == SUB) o = (a[31] != b[31]) && (r[31] != a[31]);
        return {o, r[31], r[32], r[31:0] == 32'd0};
    endfunction

    always_comb alu_out = aluCalc(alu_a[31:0], alu_b[31:0], alu_funsel);
    always @(posedge clk) if (alu_wf) alu_flags <= aluFlags(alu_a[31:0], alu_b[31:0], alu_funsel);

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] fs, input logic wf);
        if (port == 0) begin
            req0_valid = valid; req0_a = a; req0_b = b; req0_funsel = fs; req0_wf = wf;
        end else begin
            req1_valid = valid; req1_a = a; req1_b = b; req1_funsel = fs; req1_wf = wf;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: m_age counts cycles since the accepted handshake (-1 = free)
    logic        m_on = 1'b0;
    int          m_age = -1;
    int          m_last = 1;
    int          m_grant;
    int          m_owner = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [4:0]  m_fs = '0;
    logic        m_wf = 1'b0;
    logic [3:0]  m_alu_flags = 4'b0000;
    logic [31:0] m_rsp_data = '0;
    logic [3:0]  m_rsp_flags = '0;

    always @(negedge clk) begin
        logic drive;
        m_grant = -1;
        if (m_age < 0 && !rst) begin
            if (req0_valid && req1_valid) m_grant = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          m_grant = 0;
            else if (req1_valid)          m_grant = 1;
        end
        drive = (m_age == 1) || (m_age == 2);
        if (m_on) begin
            checkOutput("m_ready0", 64'(req0_ready), 64'(m_grant == 0));
            checkOutput("m_ready1", 64'(req1_ready), 64'(m_grant == 1));
            checkOutput("m_rsp0", 64'(rsp0_valid), 64'(m_age == 3 && m_owner == 0));
            checkOutput("m_rsp1", 64'(rsp1_valid), 64'(m_age == 3 && m_owner == 1));
            checkOutput("m_rsp_data", 64'(rsp_data), 64'(m_rsp_data));
            checkOutput("m_rsp_flags", 64'(rsp_flags), 64'(m_rsp_flags));
            checkOutput("m_alu_a", 64'(alu_a), drive ? 64'(m_a) : 64'd0);
            checkOutput("m_alu_b", 64'(alu_b), drive ? 64'(m_b) : 64'd0);
            checkOutput("m_alu_fs", 64'(alu_funsel), drive ? 64'(m_fs) : 64'd0);
            checkOutput("m_alu_wf", 64'(alu_wf), 64'(m_age == 1 && m_wf));
        end
        if (m_age == 1 && m_wf) m_alu_flags = aluFlags(m_a, m_b, m_fs);
        if (rst) begin
            m_on = 1'b1; m_age = -1; m_last = 1; m_rsp_data = '0; m_rsp_flags = '0;
        end else if (m_on) begin
            if (m_age == 2) begin
                m_rsp_data  = aluCalc(m_a, m_b, m_fs) & 33'h0_FFFF_FFFF;
                m_rsp_flags = m_alu_flags;
                m_age = 3;
            end else if (m_age == 3) begin
                m_age = -1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_grant >= 0) begin
                m_owner = m_grant;
                m_last  = m_grant;
                m_age   = 1;
                if (m_grant == 0) begin m_a = req0_a; m_b = req0_b; m_fs = req0_funsel; m_wf = req0_wf; end
                else              begin m_a = req1_a; m_b = req1_b; m_fs = req1_funsel; m_wf = req1_wf; end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) step();
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset_rsp_flags", 64'(rsp_flags), 64'd0);
        checkOutput("reset_alu_wf", 64'(alu_wf), 64'd0);
        checkOutput("reset_rsp0", 64'(rsp0_valid), 64'd0);
        step();

        $display("[TB] single request on port 0");
        applyStimulus(0, 1'b1, 32'd5, 32'd3, ADD, 1'b1);
        @(negedge clk);
        checkOutput("t1_ready0", 64'(req0_ready), 64'd1);
        checkOutput("t1_ready1", 64'(req1_ready), 64'd0);
        step();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("t1_issue_wf", 64'(alu_wf), 64'd1);
        checkOutput("t1_issue_a", 64'(alu_a), 64'd5);
        step();
        @(negedge clk);
        checkOutput("t1_capture_wf", 64'(alu_wf), 64'd0);
        step();
        @(negedge clk);
        checkOutput("t1_rsp0", 64'(rsp0_valid), 64'd1);
        checkOutput("t1_rsp1", 64'(rsp1_valid), 64'd0);
        checkOutput("t1_data", 64'(rsp_data), 64'd8);
        checkOutput("t1_flags", 64'(rsp_flags), 64'd0);
        step();

        $display("[TB] tie after reset, both held valid");
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 32'd10, 32'd20, ADD, 1'b1);
        applyStimulus(1, 1'b1, 32'd100, 32'd1, SUB, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 4 == 0) begin
                checkOutput("t2_ready0", 64'(req0_ready), 64'((k / 4) % 2 == 0));
                checkOutput("t2_ready1", 64'(req1_ready), 64'((k / 4) % 2 == 1));
            end
            step();
        end
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (4) step();

        $display("[TB] flag preservation on WF=0");
        applyStimulus(1, 1'b1, 32'd7, 32'd7, SUB, 1'b1);
        @(negedge clk);
        checkOutput("t3_ready1", 64'(req1_ready), 64'd1);
        step();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (2) step();
        @(negedge clk);
        checkOutput("t3_rsp1", 64'(rsp1_valid), 64'd1);
        checkOutput("t3_flags_z", 64'(rsp_flags), 64'd1);
        step();
        applyStimulus(1, 1'b1, 32'd1, 32'd1, ADD, 1'b0);
        @(negedge clk);
        checkOutput("t3b_ready1", 64'(req1_ready), 64'd1);
        step();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("t3b_no_wf", 64'(alu_wf), 64'd0);
            if (i == 3) begin
                checkOutput("t3b_data", 64'(rsp_data), 64'd2);
                checkOutput("t3b_flags", 64'(rsp_flags), 64'd1);
            end
            step();
        end

        $display("[TB] withdrawn request");
        applyStimulus(0, 1'b1, 32'd2, 32'd2, ADD, 1'b1);
        @(negedge clk);
        checkOutput("t4_ready0", 64'(req0_ready), 64'd1);
        step();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        applyStimulus(1, 1'b1, 32'd50, 32'd60, ADD, 1'b1);
        @(negedge clk);
        checkOutput("t4_busy_ready1", 64'(req1_ready), 64'd0);
        step();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (2) step();
        applyStimulus(0, 1'b1, 32'd3, 32'd4, ADD, 1'b0);
        applyStimulus(1, 1'b1, 32'd11, 32'd22, ADD, 1'b1);
        @(negedge clk);
        checkOutput("t4_tie_ready1", 64'(req1_ready), 64'd1);
        checkOutput("t4_tie_ready0", 64'(req0_ready), 64'd0);
        step();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) step();

        $display("[TB] reset during capture");
        applyStimulus(0, 1'b1, 32'd9, 32'd9, ADD, 1'b1);
        @(negedge clk);
        checkOutput("t5_ready0", 64'(req0_ready), 64'd1);
        step();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        rst = 1'b1;
        applyStimulus(1, 1'b1, 32'd40, 32'd2, SUB, 1'b1);
        @(negedge clk);
        checkOutput("t5_rst_ready1", 64'(req1_ready), 64'd0);
        step();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 32'd6, 32'd7, ADD, 1'b1);
        @(negedge clk);
        checkOutput("t5_after_ready0", 64'(req0_ready), 64'd1);
        checkOutput("t5_after_rsp0", 64'(rsp0_valid), 64'd0);
        checkOutput("t5_after_data", 64'(rsp_data), 64'd0);
        checkOutput("t5_after_alu_a", 64'(alu_a), 64'd0);
        step();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) step();

        $display("[TB] reset during issue");
        applyStimulus(1, 1'b1, 32'h8000_0000, 32'h8000_0000, ADD, 1'b1);
        step();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5b_wf_forced", 64'(alu_wf), 64'd0);
        checkOutput("t5b_alu_a", 64'(alu_a), 64'd0);
        step();

        $display("[TB] reset with valid while idle");
        rst = 1'b1;
        applyStimulus(1, 1'b1, 32'd3, 32'd3, SUB, 1'b1);
        @(negedge clk);
        checkOutput("t5c_rst_ready1", 64'(req1_ready), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5c_ready1", 64'(req1_ready), 64'd1);
        step();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) step();

        $display("[TB] idle drive");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t6_alu_a", 64'(alu_a), 64'd0);
            checkOutput("t6_alu_b", 64'(alu_b), 64'd0);
            checkOutput("t6_alu_fs", 64'(alu_funsel), 64'd0);
            checkOutput("t6_alu_wf", 64'(alu_wf), 64'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
